// File: rtl/kim_fifo_pkg.sv
// Shared definitions for the kim FIFO write-side and read-side controllers.
package kim_fifo_pkg;

    typedef enum logic {
        StIdle  = 1'b0,
        StBurst = 1'b1
    } arb_state_e;

    localparam int unsigned KimFifoDefaultWidth = 32;

    // Occupancy from pointer pair; caller truncates to LOG2_DEPTH+1 bits.
    function automatic logic [31:0] kim_fifo_level(input logic [31:0] w_ptr,
                                                   input logic [31:0] r_ptr,
                                                   input logic        w_back,
                                                   input logic        r_back,
                                                   input logic [31:0] depth);
        return (w_back == r_back) ? (w_ptr - r_ptr) : (depth - r_ptr + w_ptr);
    endfunction

endpackage

// File: rtl/kim_fifo_wr_arb_if.sv
// Requester and FIFO-memory write-side bus of the kim FIFO write arbiter.
interface kim_fifo_wr_arb_if
    import kim_fifo_pkg::*;
#(
    parameter int unsigned FIFO_DATA_LENGTH = KimFifoDefaultWidth,
    parameter int unsigned FIFO_LOG2_DEPTH  = 2,
    parameter int unsigned NUM_REQ          = 4,
    parameter int unsigned LOG2_REQ         = 2
);
    logic [NUM_REQ-1:0]                  req_valid;
    logic [NUM_REQ-1:0]                  req_last;
    logic [NUM_REQ*FIFO_DATA_LENGTH-1:0] req_data;
    logic [NUM_REQ-1:0]                  req_ready;
    logic                                w_hs;
    logic [FIFO_DATA_LENGTH-1:0]         data_in;
    logic [FIFO_LOG2_DEPTH-1:0]          w_ptr;
    logic [FIFO_LOG2_DEPTH-1:0]          r_ptr;
    logic                                w_back;
    logic                                r_back;
    logic                                full;
    logic                                empty;
    logic [FIFO_LOG2_DEPTH:0]            level;
    logic                                busy;
    logic [LOG2_REQ-1:0]                 owner;

    modport slave (
        input  req_valid, req_last, req_data, w_ptr, r_ptr, w_back, r_back,
        output req_ready, w_hs, data_in, full, empty, level, busy, owner
    );

    modport master (
        output req_valid, req_last, req_data, w_ptr, r_ptr, w_back, r_back,
        input  req_ready, w_hs, data_in, full, empty, level, busy, owner
    );

endinterface

// File: rtl/kim_rr_pick.sv
// Rotating-priority picker: first set request at or above i_rr_ptr, wrapping modulo NUM_REQ.
module kim_rr_pick #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned LOG2_REQ = 2
) (
    input  logic [NUM_REQ-1:0]  i_req_valid,
    input  logic [LOG2_REQ-1:0] i_rr_ptr,
    output logic                o_found,
    output logic [LOG2_REQ-1:0] o_winner
);

    int unsigned w_idx;

    // Scan from the farthest offset down so the nearest requester wins.
    always_comb begin
        o_found  = 1'b0;
        o_winner = '0;
        w_idx    = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = (32'(i_rr_ptr) + 32'(k)) % NUM_REQ;
            if (i_req_valid[w_idx]) begin
                o_found  = 1'b1;
                o_winner = LOG2_REQ'(w_idx);
            end
        end
    end

endmodule

// File: rtl/kim_fifo_wr_arb.sv
// Round-robin burst arbiter for the kim FIFO write port.
// Optional per-requester beat counters are enabled by defining FIFO_ARB_STAT_EN.
module kim_fifo_wr_arb
    import kim_fifo_pkg::*;
#(
    parameter int unsigned FIFO_DATA_LENGTH = KimFifoDefaultWidth,
    parameter int unsigned FIFO_DATA_DEPTH  = 4,
    parameter int unsigned FIFO_LOG2_DEPTH  = 2,
    parameter int unsigned NUM_REQ          = 4,
    parameter int unsigned LOG2_REQ         = 2,
    parameter int unsigned MAX_BURST        = 8,
    parameter int unsigned GAP_MAX          = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    kim_fifo_wr_arb_if.slave        bus
`ifdef FIFO_ARB_STAT_EN
    ,
    output logic [NUM_REQ*16-1:0]   stat_cnt
`endif
);

    localparam int unsigned BeatW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int unsigned GapW  = (GAP_MAX > 1) ? $clog2(GAP_MAX) : 1;

    arb_state_e          r_state;
    logic [LOG2_REQ-1:0] r_owner;
    logic [LOG2_REQ-1:0] r_rr_ptr;
    logic [BeatW-1:0]    r_beat_cnt;
    logic [GapW-1:0]     r_gap_cnt;

    logic                w_found;
    logic [LOG2_REQ-1:0] w_winner;
    logic [LOG2_REQ-1:0] w_next_rr;
    logic                w_own_valid;
    logic                w_own_last;
    logic                w_full;
    logic                w_whs;
    logic                w_release;

    kim_rr_pick #(
        .NUM_REQ  (NUM_REQ),
        .LOG2_REQ (LOG2_REQ)
    ) u_pick (
        .i_req_valid (bus.req_valid),
        .i_rr_ptr    (r_rr_ptr),
        .o_found     (w_found),
        .o_winner    (w_winner)
    );

    assign w_full      = (bus.w_ptr == bus.r_ptr) && (bus.w_back != bus.r_back);
    assign bus.full    = w_full;
    assign bus.empty   = (bus.w_ptr == bus.r_ptr) && (bus.w_back == bus.r_back);
    assign bus.level   = (FIFO_LOG2_DEPTH + 1)'(kim_fifo_level(32'(bus.w_ptr), 32'(bus.r_ptr),
                                                               bus.w_back, bus.r_back,
                                                               32'(FIFO_DATA_DEPTH)));

    assign w_own_valid = bus.req_valid[r_owner];
    assign w_own_last  = bus.req_last[r_owner];
    assign w_whs       = (r_state == StBurst) && w_own_valid && !w_full;
    assign w_next_rr   = (r_owner == LOG2_REQ'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;

    // A full-stall with valid high is neither a beat nor a gap.
    assign w_release   = w_whs ? (w_own_last || (r_beat_cnt == BeatW'(MAX_BURST - 1)))
                               : (!w_own_valid && (r_gap_cnt == GapW'(GAP_MAX - 1)));

    assign bus.w_hs    = w_whs;
    assign bus.data_in = bus.req_data[32'(r_owner) * FIFO_DATA_LENGTH +: FIFO_DATA_LENGTH];
    assign bus.busy    = (r_state == StBurst);
    assign bus.owner   = r_owner;

    always_comb begin
        bus.req_ready = '0;
        if (r_state == StBurst) begin
            bus.req_ready[r_owner] = !w_full;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
            r_gap_cnt  <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_found) begin
                        r_owner    <= w_winner;
                        r_beat_cnt <= '0;
                        r_gap_cnt  <= '0;
                        r_state    <= StBurst;
                    end
                end
                StBurst: begin
                    if (w_whs) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                        r_gap_cnt  <= '0;
                    end else if (!w_own_valid) begin
                        r_gap_cnt  <= r_gap_cnt + 1'b1;
                    end
                    if (w_release) begin
                        r_state  <= StIdle;
                        r_rr_ptr <= w_next_rr;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

`ifdef FIFO_ARB_STAT_EN
    logic [15:0] r_stat [NUM_REQ];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_stat[i] <= '0;
            end
        end else if (w_whs && (r_stat[r_owner] != 16'hFFFF)) begin
            r_stat[r_owner] <= r_stat[r_owner] + 16'd1;
        end
    end

    always_comb begin
        stat_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            stat_cnt[i*16 +: 16] = r_stat[i];
        end
    end
`endif

endmodule

// File: tb/tb_kim_fifo_wr_arb.sv
// Randomized bench for kim_fifo_wr_arb against a transaction-level arbiter and FIFO model.
module tb_kim_fifo_wr_arb;

    localparam int W  = 32;
    localparam int D  = 4;
    localparam int L  = 2;
    localparam int N  = 4;
    localparam int LR = 2;
    localparam int MB = 3;
    localparam int GM = 4;
    localparam int NCYC = 4000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    kim_fifo_wr_arb_if #(
        .FIFO_DATA_LENGTH (W),
        .FIFO_LOG2_DEPTH  (L),
        .NUM_REQ          (N),
        .LOG2_REQ         (LR)
    ) u_if ();

`ifdef FIFO_ARB_STAT_EN
    logic [N*16-1:0] stat_cnt;
`endif

    kim_fifo_wr_arb #(
        .FIFO_DATA_LENGTH (W),
        .FIFO_DATA_DEPTH  (D),
        .FIFO_LOG2_DEPTH  (L),
        .NUM_REQ          (N),
        .LOG2_REQ         (LR),
        .MAX_BURST        (MB),
        .GAP_MAX          (GM)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (u_if.slave)
`ifdef FIFO_ARB_STAT_EN
        ,
        .stat_cnt (stat_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Pending beats per requester: what each requester still has to deliver.
    logic [W-1:0] q_data [N][$];
    bit           q_last [N][$];

    // Reference model: who holds the grant and how the burst is going, in plain counts.
    bit   m_busy;
    int   m_owner, m_rr, m_beats, m_gap;
    int   count, wp, rp;
    int   stat_m [N];

    logic [N-1:0] v;
    logic [N-1:0] exp_ready;
    logic         exp_full, exp_whs;
    bit           rd, did_rst;
    int           rd_div, refill_div;

    task automatic drive_ptrs();
        u_if.w_ptr  = L'(wp % D);
        u_if.w_back = 1'((wp / D) % 2);
        u_if.r_ptr  = L'(rp % D);
        u_if.r_back = 1'((rp / D) % 2);
    endtask

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_rr = 0; m_beats = 0; m_gap = 0;
        count = 0; wp = 0; rp = 0;
        for (int i = 0; i < N; i++) stat_m[i] = 0;
    endtask

    task automatic release_grant();
        m_busy = 0;
        m_rr   = (m_owner + 1) % N;
    endtask

    initial begin
        model_reset();
        did_rst = 0;
        u_if.req_valid = '0;
        u_if.req_last  = '0;
        u_if.req_data  = {$urandom, $urandom, $urandom, $urandom};
        drive_ptrs();
        #2;
        check_eq("rst_busy",  64'(u_if.busy), 64'(0));
        check_eq("rst_owner", 64'(u_if.owner), 64'(0));
        check_eq("rst_ready", 64'(u_if.req_ready), 64'(0));
        check_eq("rst_whs",   64'(u_if.w_hs), 64'(0));
        check_eq("rst_data",  64'(u_if.data_in), 64'(u_if.req_data[W-1:0]));
        check_eq("rst_empty", 64'(u_if.empty), 64'(1));
        check_eq("rst_level", 64'(u_if.level), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            if (!rst_n) rst_n = 1'b1;

            if (cyc < 1000)      begin rd_div = 8; refill_div = 2; end
            else if (cyc < 2000) begin rd_div = 2; refill_div = 3; end
            else                 begin rd_div = 3; refill_div = 7; end

            for (int i = 0; i < N; i++) begin
                if (q_data[i].size() < 5 && ($urandom % refill_div) == 0) begin
                    q_data[i].push_back($urandom);
                    q_last[i].push_back(($urandom % 4) == 0);
                end
                if (q_data[i].size() > 0 && ($urandom % 5) != 0) begin
                    v[i] = 1'b1;
                    u_if.req_data[i*W +: W] = q_data[i][0];
                    u_if.req_last[i]        = q_last[i][0];
                end else begin
                    v[i] = 1'b0;
                    u_if.req_data[i*W +: W] = $urandom;
                    u_if.req_last[i]        = 1'($urandom % 2);
                end
            end
            u_if.req_valid = v;
            rd = (count > 0) && (($urandom % rd_div) == 0);
            drive_ptrs();

            // Asynchronous reset in the middle of a burst, away from any clock edge.
            if (cyc > 2000 && !did_rst && m_busy && m_beats >= 1) begin
                #2;
                rst_n = 1'b0;
                #1;
                check_eq("arst_whs",   64'(u_if.w_hs), 64'(0));
                check_eq("arst_ready", 64'(u_if.req_ready), 64'(0));
                check_eq("arst_busy",  64'(u_if.busy), 64'(0));
                check_eq("arst_owner", 64'(u_if.owner), 64'(0));
                model_reset();
                did_rst = 1;
                continue;
            end

            #1;
            exp_full = (count == D);
            check_eq("full",  64'(u_if.full), 64'(exp_full));
            check_eq("empty", 64'(u_if.empty), 64'(count == 0));
            check_eq("level", 64'(u_if.level), 64'(count));
            check_eq("busy",  64'(u_if.busy), 64'(m_busy));
            check_eq("owner", 64'(u_if.owner), 64'(m_owner));
            exp_ready = '0;
            exp_whs   = 1'b0;
            if (m_busy) begin
                exp_ready[m_owner] = !exp_full;
                exp_whs = v[m_owner] && !exp_full;
                check_eq("data_in", 64'(u_if.data_in), 64'(u_if.req_data[m_owner*W +: W]));
            end
            check_eq("ready", 64'(u_if.req_ready), 64'(exp_ready));
            check_eq("w_hs",  64'(u_if.w_hs), 64'(exp_whs));
            if (exp_whs) begin
                check_eq("beat_data", 64'(u_if.data_in), 64'(q_data[m_owner][0]));
            end

            @(posedge clk);
            if (m_busy) begin
                if (exp_whs) begin
                    bit lst;
                    lst = q_last[m_owner][0];
                    void'(q_data[m_owner].pop_front());
                    void'(q_last[m_owner].pop_front());
                    stat_m[m_owner]++;
                    count++;
                    wp = (wp + 1) % (2 * D);
                    m_beats++;
                    m_gap = 0;
                    if (lst || m_beats == MB) release_grant();
                end else if (!v[m_owner]) begin
                    m_gap++;
                    if (m_gap == GM) release_grant();
                end
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (!m_busy && v[(m_rr + k) % N]) begin
                        m_busy  = 1;
                        m_owner = (m_rr + k) % N;
                        m_beats = 0;
                        m_gap   = 0;
                    end
                end
            end
            if (rd) begin
                count--;
                rp = (rp + 1) % (2 * D);
            end
        end

        check_eq("reset_injected", 64'(did_rst), 64'(1));
`ifdef FIFO_ARB_STAT_EN
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            check_eq($sformatf("stat_cnt%0d", i), 64'(stat_cnt[i*16 +: 16]), 64'(stat_m[i]));
        end
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/kim_fifo_wr_arb.md
Name: kim_fifo_wr_arb

Overview:
Round-robin write-port arbiter and controller for the kim FIFO memory. It shares the single FIFO write port among N requesters and grants ownership in bursts. It derives full, empty and level from the FIFO's w_ptr/r_ptr/w_back/r_back, and drives the FIFO's w_hs and data_in. It sits between the requester ports and the FIFO memory; the read side is not touched.

Parameters:
- FIFO_DATA_LENGTH, 32, data width in bits
- FIFO_DATA_DEPTH, 4, FIFO entries (power of 2)
- FIFO_LOG2_DEPTH, 2, log2(FIFO_DATA_DEPTH)
- NUM_REQ, 4, number of requesters (>=2)
- LOG2_REQ, 2, log2(NUM_REQ)
- MAX_BURST, 8, maximum beats per grant (>=1)
- GAP_MAX, 4, consecutive idle owner cycles before forced release (>=1)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  per-requester data valid
- req_last  in  NUM_REQ  per-requester end-of-burst marker
- req_data  in  NUM_REQ*FIFO_DATA_LENGTH  requester i data at bits [i*W +: W]
- req_ready  out  NUM_REQ  per-requester accept
- w_hs  out  1  write strobe to FIFO memory
- data_in  out  FIFO_DATA_LENGTH  write data to FIFO memory
- w_ptr  in  FIFO_LOG2_DEPTH  FIFO write pointer
- r_ptr  in  FIFO_LOG2_DEPTH  FIFO read pointer
- w_back  in  1  FIFO write wrap bit
- r_back  in  1  FIFO read wrap bit
- full  out  1  FIFO full
- empty  out  1  FIFO empty
- level  out  FIFO_LOG2_DEPTH+1  occupancy
- busy  out  1  a burst is in progress
- owner  out  LOG2_REQ  current grant holder

Behaviour:
- Clocking and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset state:
  - state=IDLE; owner=0; rr_ptr=0; beat_cnt=0; gap_cnt=0.
  - busy=0, req_ready=0, w_hs=0.
  - data_in = req_data slice of owner 0.
- Status (combinational):
  - full = (w_ptr==r_ptr) && (w_back!=r_back).
  - empty = (w_ptr==r_ptr) && (w_back==r_back).
  - level = w_back==r_back ? w_ptr-r_ptr : DEPTH-r_ptr+w_ptr, evaluated at LOG2_DEPTH+1 bits.
- IDLE state:
  - req_ready=0 and w_hs=0.
  - If any req_valid is set, the winner is the first set bit searching upward from rr_ptr, with modulo NUM_REQ wrap.
  - On a winner: register owner, beat_cnt=0, gap_cnt=0, then go to BURST.
  - Arbitration latency is 1 cycle.
- BURST state:
  - busy=1.
  - req_ready[owner] = !full; every other req_ready is 0.
  - w_hs = req_valid[owner] && !full, combinational. data_in = req_data[owner].
  - On w_hs: beat_cnt+1 and gap_cnt=0.
  - On a cycle where req_valid[owner]=0: gap_cnt+1. A full-stall cycle with valid high does not count as a gap.
- Leaving BURST (return to IDLE, rr_ptr=owner+1 mod NUM_REQ) on any of:
  - w_hs && req_last[owner];
  - w_hs && beat_cnt==MAX_BURST-1;
  - !req_valid[owner] && gap_cnt==GAP_MAX-1.
- No back-to-back grant: at least one IDLE cycle separates bursts.
- Simultaneous events: last and MAX_BURST on the same beat give one release. A full FIFO at the last beat holds the state until the beat is accepted.
- Wrap-around: the rr_ptr increment wraps NUM_REQ-1 to 0.
- Reset mid-burst: immediate return to the reset state. Partial bursts are not resumed.
- Never writes when full. Requester-side data is never dropped: a beat is consumed only on valid && ready.

Optional Feature:
- Macro: FIFO_ARB_STAT_EN.
- When defined:
  - Extra output stat_cnt, width NUM_REQ*16: per-requester accepted-beat counters.
  - Each counter increments on w_hs for the current owner and saturates at 16'hFFFF.
  - Counters clear on reset.
- When undefined: the port and counters are absent. Behaviour is otherwise identical.

Decomposition:
- Package kim_fifo_pkg holds:
  - the state encoding (IDLE=1'b0, BURST=1'b1);
  - a default-width constant;
  - the level-calculation function, shared with the future read-side controller.
- One sub-module, kim_rr_pick: combinational rotating-priority picker taking (req_valid, rr_ptr) and returning (found, winner).

Test Plan:
1. Req0 sends 3 beats 0xA0,0xA1,0xA2 with last on the 3rd, FIFO empty. Required: grant one cycle after valid; three w_hs pulses with data_in matching; level 0->3; back to IDLE; rr_ptr=1.
2. Req0 and Req2 valid continuously, MAX_BURST=2. Required: grant order 0,2,0,2; each burst is exactly 2 beats; one IDLE cycle between bursts.
3. Req1 streams into a DEPTH=4 FIFO with no reads. Required: 4 writes; full=1 and level=4; req_ready[1]=0 and no w_hs while full. Then pop 1 externally (r_ptr+1): exactly one more write is accepted.
4. Req3 sends 1 beat without last, then drops valid, GAP_MAX=4. Required: burst released after 4 idle cycles; busy falls; owner reusable by others next cycle.
5. Assert rst_n low mid-burst at beat 2. Required: in the same cycle (asynchronous) w_hs=0, req_ready=0, busy=0, owner=0. After release, arbitration restarts from req0.
6. With FIFO_ARB_STAT_EN: scenario 2 for 10 bursts. Required: stat_cnt[0]=10 and stat_cnt[2]=10; others 0.
